// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator for raster-order pixels, built from two line memories and a 3x3 shift register.
// Define SOBEL_WIN_DEBUG_EN to add dbg_row/dbg_col, which report the position of the pixel behind each window.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    localparam int COL_W      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    input  logic [PIXEL_WIDTH-1:0]   pix_data,
    output logic                     window_valid,
    output logic [PIXEL_WIDTH*9-1:0] window_flat,
`ifdef SOBEL_WIN_DEBUG_EN
    output logic [ROW_W-1:0]         dbg_row,
    output logic [COL_W-1:0]         dbg_col,
`endif
    output logic                     frame_done
);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] ACTIVE   = 1'b1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [0:0]             state;
    logic [ROW_W-1:0]       row;
    logic [COL_W-1:0]       col;

    logic [PIXEL_WIDTH-1:0] line1_mem [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line2_mem [IMG_WIDTH];

    // win_sr[k] holds pk of the most recent neighbourhood; entries 0,3,6 are the oldest column
    logic [PIXEL_WIDTH-1:0] win_sr  [9];
    logic [PIXEL_WIDTH-1:0] win_nxt [9];

    logic                     accept_p0;
    logic                     win_hit_p0;
    logic                     last_p0;
    logic [ROW_W-1:0]         cur_row_p0;
    logic [COL_W-1:0]         cur_col_p0;
    logic [PIXEL_WIDTH-1:0]   line1_rd_p0;
    logic [PIXEL_WIDTH-1:0]   line2_rd_p0;
    logic [PIXEL_WIDTH*9-1:0] flat_nxt_p0;

    // Stage p0: qualify the incoming pixel and locate it in the frame
    always_comb begin
        accept_p0  = pix_valid && ((state == ACTIVE) || pix_sof);
        cur_row_p0 = pix_sof ? '0 : row;
        cur_col_p0 = pix_sof ? '0 : col;
        win_hit_p0 = accept_p0 && (cur_row_p0 >= ROW_TWO) && (cur_col_p0 >= COL_TWO);
        last_p0    = accept_p0 && (cur_row_p0 == ROW_LAST) && (cur_col_p0 == COL_LAST);
    end

    assign line1_rd_p0 = line1_mem[cur_col_p0];
    assign line2_rd_p0 = line2_mem[cur_col_p0];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r*3]     = win_sr[r*3 + 1];
            win_nxt[r*3 + 1] = win_sr[r*3 + 2];
        end
        win_nxt[2] = line2_rd_p0;
        win_nxt[5] = line1_rd_p0;
        win_nxt[8] = pix_data;
        flat_nxt_p0 = '0;
        for (int k = 0; k < 9; k++) begin
            flat_nxt_p0[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win_nxt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SOF;
            row   <= '0;
            col   <= '0;
        end else if (accept_p0) begin
            state <= last_p0 ? WAIT_SOF : ACTIVE;
            if (cur_col_p0 == COL_LAST) begin
                col <= '0;
                row <= last_p0 ? '0 : cur_row_p0 + ROW_W'(1);
            end else begin
                col <= cur_col_p0 + COL_W'(1);
                row <= cur_row_p0;
            end
        end
    end

    // Line memories age by one row per write; stale contents are never exposed because rows 0 and 1 make no windows
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            line2_mem[cur_col_p0] <= line1_rd_p0;
            line1_mem[cur_col_p0] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                win_sr[k] <= '0;
            end
        end else if (accept_p0) begin
            for (int k = 0; k < 9; k++) begin
                win_sr[k] <= win_nxt[k];
            end
        end
    end

    // Stage p1: registered window and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_valid <= 1'b0;
            window_flat  <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= win_hit_p0;
            frame_done   <= last_p0;
            if (win_hit_p0) begin
                window_flat <= flat_nxt_p0;
            end
        end
    end

`ifdef SOBEL_WIN_DEBUG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_row <= '0;
            dbg_col <= '0;
        end else if (win_hit_p0) begin
            dbg_row <= cur_row_p0;
            dbg_col <= cur_col_p0;
        end
    end
`endif

endmodule
